// File: rtl/mips_pkg.sv
// Shared decode constants and multiply/divide FSM state type for the execute stage.
package mips_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} muldiv_state_e;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_hilo_move(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-step shift/add multiplier and restoring divider on unsigned operands.
// Multiply: acc = {0, multiplier}, add multiplicand to the top half, shift right.
// Divide:   acc = {0, dividend}, shift left, trial-subtract divisor from the top half.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   m_reg;
    logic              div_reg;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;

    always_comb begin
        sum       = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, m_reg};
        rem_shift = acc_reg[2*XLEN-1:XLEN-1];
        // Partial remainder stays below the divisor, so the extra top bit of diff is the borrow.
        diff      = rem_shift - {1'b0, m_reg};
        acc_next  = acc_reg;
        if (div_reg) begin
            if (!diff[XLEN])
                acc_next = {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            else
                acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
        end else begin
            if (acc_reg[0])
                acc_next = {sum, acc_reg[XLEN-1:1]};
            else
                acc_next = {1'b0, acc_reg[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            m_reg   <= '0;
            div_reg <= 1'b0;
        end else if (load) begin
            acc_reg <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
            m_reg   <= is_div ? op_b : op_a;
            div_reg <= is_div;
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage multiply/divide unit: control FSM, sign handling, HI/LO registers,
// pipeline stall and MFHI/MFLO read path around the iterative datapath.
module alu_muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mf_data
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     state_reg;
    logic [CW-1:0]     cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic [XLEN-1:0]   rs_reg;
    logic [XLEN-1:0]   rt_reg;
    logic [5:0]        funct_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;

    logic              r_type;
    logic              accept;
    logic              mt_write;
    logic              op_signed;
    logic              op_div;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q_raw;
    logic [XLEN-1:0]   r_raw;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign r_type   = op_valid && (ALUOp == ALUOP_RTYPE);
    assign accept   = (state_reg == IDLE) && r_type && is_muldiv(funct) && !flush;
    assign mt_write = r_type && ((funct == FUNCT_MTHI) || (funct == FUNCT_MTLO)) &&
                      !busy_reg && !flush;
    assign stall    = r_type && (is_muldiv(funct) || is_hilo_move(funct)) && busy_reg;

    always_comb begin
        mf_data = '0;
        if (funct == FUNCT_MFHI)
            mf_data = hi_reg;
        else if (funct == FUNCT_MFLO)
            mf_data = lo_reg;
    end

    assign op_signed = (funct_reg == FUNCT_MULT) || (funct_reg == FUNCT_DIV);
    assign op_div    = (funct_reg == FUNCT_DIV)  || (funct_reg == FUNCT_DIVU);
    assign abs_a     = (op_signed && rs_reg[XLEN-1]) ? -rs_reg : rs_reg;
    assign abs_b     = (op_signed && rt_reg[XLEN-1]) ? -rt_reg : rt_reg;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_reg == PREP),
        .step   (state_reg == RUN),
        .is_div (op_div),
        .op_a   (abs_a),
        .op_b   (abs_b),
        .acc    (acc)
    );

    // MIN / -1 needs no special case: |MIN| / 1 = MIN unsigned, and the quotient stays positive.
    always_comb begin
        prod   = neg_q_reg ? -acc : acc;
        q_raw  = acc[XLEN-1:0];
        r_raw  = acc[2*XLEN-1:XLEN];
        fix_hi = prod[2*XLEN-1:XLEN];
        fix_lo = prod[XLEN-1:0];
        if (op_div) begin
            if (rt_reg == '0) begin
                fix_lo = '1;
                fix_hi = rs_reg;
            end else begin
                fix_lo = neg_q_reg ? -q_raw : q_raw;
                fix_hi = neg_r_reg ? -r_raw : r_raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            funct_reg <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (mt_write) begin
                if (funct == FUNCT_MTHI)
                    hi_reg <= rs_val;
                else
                    lo_reg <= rs_val;
            end
            if (state_reg != IDLE && flush) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            rs_reg    <= rs_val;
                            rt_reg    <= rt_val;
                            funct_reg <= funct;
                            busy_reg  <= 1'b1;
                            state_reg <= PREP;
                        end
                    end
                    PREP: begin
                        neg_q_reg <= op_signed && (rs_reg[XLEN-1] ^ rt_reg[XLEN-1]);
                        neg_r_reg <= op_signed && rs_reg[XLEN-1];
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                    RUN: begin
                        if (cnt_reg == CW'(XLEN - 1)) begin
                            cnt_reg   <= '0;
                            state_reg <= FIX;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    FIX: begin
                        hi_reg    <= fix_hi;
                        lo_reg    <= fix_lo;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: directed mul/div vectors, stall/MF/MT, flush and reset.
module tb_alu_muldiv_unit;
    import mips_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk;
    logic            rst_n;
    logic            op_valid;
    logic [1:0]      ALUOp;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            flush;
    logic            busy;
    logic            done;
    logic            stall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mf_data;

    alu_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .ALUOp    (ALUOp),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        int              acc_cyc;
        string           name;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done hi=0x%08h lo=0x%08h", hi, lo);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(LAT));
                $display("txn %s hi=0x%08h lo=0x%08h latency=%0d", e.name, hi, lo, cyc - e.acc_cyc);
            end
        end
    end

    // Present a mul/div for one cycle; returns #1 after its accepting edge.
    task automatic issue(input logic [5:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] eh, input logic [XLEN-1:0] el,
                         input string name, input bit expect_done);
        exp_t e;
        @(negedge clk);
        op_valid = 1'b1;
        ALUOp    = ALUOP_RTYPE;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.hi = eh; e.lo = el; e.acc_cyc = cyc; e.name = name;
            sb.push_back(e);
        end
        op_valid = 1'b0;
        funct    = 6'h00;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=pending:%0d expected=pending:0", name, sb.size());
            sb.delete();
        end
    endtask

    logic [5:0]      v_f  [8];
    logic [XLEN-1:0] v_a  [8];
    logic [XLEN-1:0] v_b  [8];
    logic [XLEN-1:0] v_hi [8];
    logic [XLEN-1:0] v_lo [8];
    string           v_nm [8];

    initial begin
        int busy_cnt;
        int bad;
        int dones;
        bit seen;

        v_f[0] = FUNCT_MULT;  v_a[0] = 32'hFFFFFFFD; v_b[0] = 32'd5;        v_hi[0] = 32'hFFFFFFFF; v_lo[0] = 32'hFFFFFFF1; v_nm[0] = "mult_m3x5";
        v_f[1] = FUNCT_DIV;   v_a[1] = 32'hFFFFFFF9; v_b[1] = 32'd2;        v_hi[1] = 32'hFFFFFFFF; v_lo[1] = 32'hFFFFFFFD; v_nm[1] = "div_m7d2";
        v_f[2] = FUNCT_DIV;   v_a[2] = 32'h80000000; v_b[2] = 32'hFFFFFFFF; v_hi[2] = 32'h00000000; v_lo[2] = 32'h80000000; v_nm[2] = "div_min_m1";
        v_f[3] = FUNCT_DIVU;  v_a[3] = 32'd100;      v_b[3] = 32'd0;        v_hi[3] = 32'd100;      v_lo[3] = 32'hFFFFFFFF; v_nm[3] = "divu_by0";
        v_f[4] = FUNCT_DIV;   v_a[4] = 32'hFFFFFFF8; v_b[4] = 32'd0;        v_hi[4] = 32'hFFFFFFF8; v_lo[4] = 32'hFFFFFFFF; v_nm[4] = "div_m8_by0";
        v_f[5] = FUNCT_DIV;   v_a[5] = 32'd7;        v_b[5] = 32'hFFFFFFFE; v_hi[5] = 32'd1;        v_lo[5] = 32'hFFFFFFFD; v_nm[5] = "div_7dm2";
        v_f[6] = FUNCT_DIVU;  v_a[6] = 32'hFFFFFFFF; v_b[6] = 32'h10;       v_hi[6] = 32'hF;        v_lo[6] = 32'h0FFFFFFF; v_nm[6] = "divu_big";
        v_f[7] = FUNCT_MULT;  v_a[7] = 32'h80000000; v_b[7] = 32'h80000000; v_hi[7] = 32'h40000000; v_lo[7] = 32'h0;        v_nm[7] = "mult_min_min";

        rst_n = 1'b0; op_valid = 1'b0; ALUOp = 2'b00; funct = 6'h00;
        rs_val = '0; rt_val = '0; flush = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned extreme product plus busy-window length.
        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else break;
        end
        chk("multu_busy_cycles", 32'(busy_cnt), 32'(LAT));
        wait_drain("multu_max");

        @(negedge clk);
        op_valid = 1'b1; ALUOp = ALUOP_RTYPE; funct = FUNCT_MFHI;
        #1;
        chk("mfhi_data", mf_data, 32'hFFFFFFFE);
        chk("mfhi_stall", 32'(stall), 32'd0);
        funct = FUNCT_MFLO;
        #1;
        chk("mflo_data", mf_data, 32'h00000001);
        op_valid = 1'b0; funct = 6'h00;

        for (int i = 0; i < 8; i++) begin
            issue(v_f[i], v_a[i], v_b[i], v_hi[i], v_lo[i], v_nm[i], 1'b1);
            wait_drain(v_nm[i]);
        end

        // MFLO held behind a running MULT 6*7.
        issue(FUNCT_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult_6x7", 1'b1);
        @(negedge clk);
        op_valid = 1'b1; ALUOp = ALUOP_RTYPE; funct = FUNCT_MFLO;
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!stall) bad++;
            @(negedge clk);
        end
        chk("mflo_done_seen", 32'(seen), 32'd1);
        chk("mflo_stall_while_busy", 32'(bad), 32'd0);
        chk("mflo_done_stall", 32'(stall), 32'd0);
        chk("mflo_done_data", mf_data, 32'd42);
        op_valid = 1'b0; funct = 6'h00;
        wait_drain("mult_6x7");

        // MTHI while busy is stalled and ignored; after done it writes.
        issue(FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7", 1'b1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b1; ALUOp = ALUOP_RTYPE; funct = FUNCT_MTHI; rs_val = 32'h1234;
            #1;
            if (!stall) bad++;
            if (hi !== 32'd0) bad++;
        end
        @(negedge clk);
        op_valid = 1'b0; funct = 6'h00;
        chk("mthi_busy_stalled", 32'(bad), 32'd0);
        chk("mthi_busy_hi_kept", hi, 32'd0);
        wait_drain("divu_100d7");
        issue(FUNCT_MTHI, 32'h1234, 32'd0, 32'd0, 32'd0, "mthi", 1'b0);
        chk("mthi_idle_hi", hi, 32'h1234);
        chk("mthi_idle_lo", lo, 32'd14);

        // Flush at RUN cycle 10 of a DIVU.
        issue(FUNCT_DIVU, 32'hFFFF0000, 32'd3, 32'd0, 32'd0, "divu_flush", 1'b0);
        repeat (12) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("flush_no_done", 32'(dones), 32'd0);
        chk("flush_hi_kept", hi, 32'h1234);
        chk("flush_lo_kept", lo, 32'd14);

        // Flush in IDLE suppresses an MTLO.
        @(negedge clk);
        op_valid = 1'b1; ALUOp = ALUOP_RTYPE; funct = FUNCT_MTLO; rs_val = 32'h55; flush = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0; funct = 6'h00; flush = 1'b0;
        chk("idle_flush_mtlo_lo", lo, 32'd14);

        // Asynchronous reset mid-RUN.
        issue(FUNCT_MULTU, 32'h1234, 32'h5678, 32'd0, 32'd0, "multu_reset", 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(FUNCT_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_reset", 1'b1);
        wait_drain("multu_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
